// File: rtl/uart_pkg.sv
// Shared UART definitions: set_baud codes, divider computation and FSM states.
// Used by uart_byte_rx and uart_byte_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    Baud9600   = 3'd0,
    Baud19200  = 3'd1,
    Baud38400  = 3'd2,
    Baud57600  = 3'd3,
    Baud115200 = 3'd4
  } baud_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_fsm_e;

  // Codes 5-7 alias to 115200.
  function automatic int unsigned baud_rate(logic [2:0] code);
    case (code)
      3'd0:    return 9600;
      3'd1:    return 19200;
      3'd2:    return 38400;
      3'd3:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Rounded clocks per oversample tick.
  function automatic logic [15:0] baud_div(int unsigned clk_freq, int unsigned oversample,
                                           logic [2:0] code);
    int unsigned rate;
    rate = baud_rate(code);
    return 16'((clk_freq + (rate * oversample) / 2) / (rate * oversample));
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rx pin plus falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic       rx_meta;
  logic       rx_d;
  logic [2:0] arm;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      arm     <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      arm     <= {arm[1:0], 1'b1};
    end
  end

  // Preset highs flush out of the chain before edges count, so a line held
  // low across reset never looks like a start bit.
  assign rx_fall = arm[2] & rx_d & ~rx_s;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 16x oversampling, 3-sample majority vote per bit.
// Define UART_RX_PARITY_EN to expect a parity bit between data and stop.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] set_baud,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       uart_state
);

  localparam logic [15:0] Div0 = baud_div(CLK_FREQ, OVERSAMPLE, 3'd0);
  localparam logic [15:0] Div1 = baud_div(CLK_FREQ, OVERSAMPLE, 3'd1);
  localparam logic [15:0] Div2 = baud_div(CLK_FREQ, OVERSAMPLE, 3'd2);
  localparam logic [15:0] Div3 = baud_div(CLK_FREQ, OVERSAMPLE, 3'd3);
  localparam logic [15:0] Div4 = baud_div(CLK_FREQ, OVERSAMPLE, 3'd4);

  logic        rx_s, rx_fall;
  uart_fsm_e   state_q;
  logic [15:0] div_sel, div_q, div_cnt;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        samp0_q, samp1_q, line_ok_q;
  logic        tick, mid, last, maj, accept;
`ifdef UART_RX_PARITY_EN
  logic        par_q;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  always_comb begin
    div_sel = Div4;
    case (set_baud)
      3'd0:    div_sel = Div0;
      3'd1:    div_sel = Div1;
      3'd2:    div_sel = Div2;
      3'd3:    div_sel = Div3;
      default: div_sel = Div4;
    endcase
  end

  // tick_cnt holds ticks already elapsed in the current bit; the third vote
  // sample is taken live on the 9th tick and the decision made the same clock.
  assign tick   = (state_q != StIdle) && (div_cnt == div_q - 16'd1);
  assign mid    = tick && (tick_cnt == 4'd8);
  assign last   = tick && (tick_cnt == 4'd15);
  assign maj    = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);
  assign accept = (state_q == StIdle) && rx_fall && line_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      samp0_q    <= 1'b0;
      samp1_q    <= 1'b0;
      line_ok_q  <= 1'b0;
      data_byte  <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      uart_state <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (rx_s) line_ok_q <= 1'b1;

      if (state_q != StIdle) begin
        div_cnt <= tick ? '0 : div_cnt + 16'd1;
        if (tick) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd6) samp0_q <= rx_s;
          if (tick_cnt == 4'd7) samp1_q <= rx_s;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StStart;
            div_q      <= div_sel;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            uart_state <= 1'b1;
          end else begin
            uart_state <= 1'b0;
          end
        end
        StStart: begin
          if (mid && maj) state_q <= StIdle;
          else if (last)  state_q <= StData;
        end
        StData: begin
          if (mid) shift_q <= {maj, shift_q[7:1]};
          if (last) begin
            bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == 3'd7) state_q <= StParity;
`else
            if (bit_cnt == 3'd7) state_q <= StStop;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (mid)  par_q   <= maj;
          if (last) state_q <= StStop;
        end
`endif
        StStop: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (mid) begin
            state_q <= StIdle;
            if (maj) begin
              rx_done   <= 1'b1;
              data_byte <= shift_q;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_q ^ (^shift_q) ^ PARITY_ODD;
`endif
            end else begin
              frame_err <= 1'b1;
              line_ok_q <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 50 MHz; parity cases need UART_RX_PARITY_EN.
module tb_uart_byte_rx;

  localparam int  Bit = 432;  // 115200 baud at 50 MHz
  localparam time Clk = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [2:0] set_baud = 3'd4;
  logic [7:0] data_byte;
  logic       rx_done, frame_err, parity_err, uart_state;

  always #5 clk = ~clk;

  uart_byte_rx #(.CLK_FREQ(50_000_000)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .set_baud   (set_baud),
    .data_byte  (data_byte),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .uart_state (uart_state)
  );

  int         n_tests = 0, n_fail = 0;
  int         n_done = 0, n_ferr = 0, n_perr = 0, n_bad = 0, n_starts = 0;
  int         run = 0, last_run = 0;
  logic       st_prev = 1'b0;
  logic [7:0] got_q[$];
  time        t_done = 0, t_stop = 0;
`ifdef UART_RX_PARITY_EN
  logic       par_force = 1'b0, par_val = 1'b0;
`endif

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_done) begin
      n_done++;
      got_q.push_back(data_byte);
      t_done = $time;
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (rx_done && frame_err) n_bad++;
    if (parity_err && !rx_done) n_bad++;
    if (uart_state && !st_prev) n_starts++;
    if (uart_state) run++;
    else if (run > 0) begin
      last_run = run;
      run = 0;
    end
    st_prev = uart_state;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    @(negedge clk);
    rx = b;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int n);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_force ? par_val : ^d, n);
`endif
    @(negedge clk);
    rx = stop;
    t_stop = $time;
    repeat (n - 1) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [2:0] baud;
    logic [7:0] exp_byte;
    int         exp_done;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[4];
  int   s_done, s_ferr, s_perr, s_starts;

  task automatic snap();
    s_done   = n_done;
    s_ferr   = n_ferr;
    s_perr   = n_perr;
    s_starts = n_starts;
  endtask

  initial begin
    vecs[0] = '{8'h00, 1'b1, 3'd5, 8'h00, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 3'd7, 8'hFF, 1, 0};
    vecs[2] = '{8'h3C, 1'b0, 3'd4, 8'hFF, 0, 1};  // bad stop keeps old byte
    vecs[3] = '{8'h81, 1'b1, 3'd6, 8'h81, 1, 0};

    repeat (3) @(negedge clk);
    check("reset data_byte", int'(data_byte), 0);
    check("reset rx_done", int'(rx_done), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset parity_err", int'(parity_err), 0);
    check("reset uart_state", int'(uart_state), 0);
    rst = 1'b0;
    drive_bit(1'b1, Bit);

    // 0xA5 with latency and busy-window checks
    snap();
    send_frame(8'hA5, 1'b1, Bit);
    drive_bit(1'b1, Bit);
    check("a5 rx_done count", n_done - s_done, 1);
    check("a5 data_byte", int'(data_byte), 'hA5);
    check("a5 frame_err count", n_ferr - s_ferr, 0);
    check_range("a5 stop-to-done clks", int'((t_done - t_stop) / Clk), 244, 248);
`ifdef UART_RX_PARITY_EN
    check_range("a5 uart_state clks", last_run, 10 * Bit, 11 * Bit);
`else
    check_range("a5 uart_state clks", last_run, 9 * Bit, 10 * Bit);
`endif

    for (int i = 0; i < 4; i++) begin
      set_baud = vecs[i].baud;
      snap();
      send_frame(vecs[i].data, vecs[i].stop, Bit);
      drive_bit(1'b1, Bit);
      check($sformatf("vec%0d rx_done count", i), n_done - s_done, vecs[i].exp_done);
      check($sformatf("vec%0d frame_err count", i), n_ferr - s_ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d data_byte", i), int'(data_byte), int'(vecs[i].exp_byte));
    end
    set_baud = 3'd4;

    // back-to-back, no idle gap
    snap();
    send_frame(8'h00, 1'b1, Bit);
    send_frame(8'hFF, 1'b1, Bit);
    drive_bit(1'b1, Bit);
    check("b2b rx_done count", n_done - s_done, 2);
    check("b2b first byte", int'(got_q[got_q.size() - 2]), 'h00);
    check("b2b second byte", int'(got_q[got_q.size() - 1]), 'hFF);

    // 100-clk glitch
    snap();
    drive_bit(1'b0, 100);
    drive_bit(1'b1, Bit);
    check("glitch rx_done count", n_done - s_done, 0);
    check("glitch frame_err count", n_ferr - s_ferr, 0);
    check("glitch start count", n_starts - s_starts, 1);
    check_range("glitch uart_state clks", last_run, 1, Bit - 1);
    check("glitch uart_state idle", int'(uart_state), 0);

    // stop low then break, then recovery
    snap();
    send_frame(8'h3C, 1'b0, Bit);
    s_starts = n_starts;
    repeat (20 * Bit) @(negedge clk);
    check("break restart count", n_starts - s_starts, 0);
    check("break uart_state", int'(uart_state), 0);
    drive_bit(1'b1, Bit);
    send_frame(8'h55, 1'b1, Bit);
    drive_bit(1'b1, Bit);
    check("break frame_err count", n_ferr - s_ferr, 1);
    check("break rx_done count", n_done - s_done, 1);
    check("break data_byte", int'(data_byte), 'h55);

    // reset mid-data
    snap();
    fork
      send_frame(8'h81, 1'b1, Bit);
      begin
        repeat (4 * Bit + Bit / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst data_byte", int'(data_byte), 0);
        check("midrst uart_state", int'(uart_state), 0);
      end
    join
    drive_bit(1'b1, Bit);
    check("midrst rx_done count", n_done - s_done, 0);
    check("midrst frame_err count", n_ferr - s_ferr, 0);
    send_frame(8'h7E, 1'b1, Bit);
    drive_bit(1'b1, Bit);
    check("post-rst rx_done count", n_done - s_done, 1);
    check("post-rst data_byte", int'(data_byte), 'h7E);

    // +3% slow line, then -3% fast line with set_baud changed mid-frame
    snap();
    send_frame(8'h5A, 1'b1, 445);
    drive_bit(1'b1, Bit);
    check("slow rx_done count", n_done - s_done, 1);
    check("slow data_byte", int'(data_byte), 'h5A);
    snap();
    fork
      send_frame(8'hC3, 1'b1, 419);
      begin
        repeat (1000) @(negedge clk);
        set_baud = 3'd0;
      end
    join
    drive_bit(1'b1, Bit);
    set_baud = 3'd4;
    check("fast rx_done count", n_done - s_done, 1);
    check("fast data_byte", int'(data_byte), 'hC3);

`ifdef UART_RX_PARITY_EN
    par_force = 1'b1;
    par_val   = 1'b1;
    snap();
    send_frame(8'h07, 1'b1, Bit);
    drive_bit(1'b1, Bit);
    check("par ok rx_done count", n_done - s_done, 1);
    check("par ok parity_err count", n_perr - s_perr, 0);
    par_val = 1'b0;
    snap();
    send_frame(8'h07, 1'b1, Bit);
    drive_bit(1'b1, Bit);
    check("par bad rx_done count", n_done - s_done, 1);
    check("par bad parity_err count", n_perr - s_perr, 1);
    check("par bad data_byte", int'(data_byte), 'h07);
    par_force = 1'b0;
`else
    check("parity_err count", n_perr, 0);
`endif

    check("illegal pulse combos", n_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
